bnn_neuron_seq: RTL

//  Binary-MLP neuron sequencer directly downstream of the 1-bit weight memory (wmem).

---
 rtl/bnn_neuron_seq.sv | 119 +++++++++++
 1 files changed

// File: rtl/bnn_neuron_seq.sv
// Binary-MLP neuron sequencer: XNOR-popcount of each 1-bit weight row against a latched activation vector.
// Latency: out_valid rises N_IN+2 edges after the accepting start edge, and again N_IN+2 edges after each handshake.
// Backpressure: result, index and weight address are frozen while out_valid=1 and out_ready=0.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start, act_in       run request (IDLE only) and activation vector latched with it
//   w_addr, w_data      weight-memory address out, 1-bit read data in (one-cycle read latency)
//   busy                high in every state except IDLE
//   out_valid/ready     result handshake; out_bit = popcount >= THRESH, out_idx = neuron index
//   done                one-cycle pulse following the last neuron's handshake
module bnn_neuron_seq #(
   parameter int N_IN      = 64,
   parameter int N_OUT     = 64,
   parameter int ADDR_W    = 13,
   parameter int BASE_ADDR = 0,
   parameter int THRESH    = 32,
   localparam int N_W      = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [N_IN-1:0]   act_in,
   output logic [ADDR_W-1:0] w_addr,
   input  logic              w_data,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_bit,
   output logic [N_W-1:0]    out_idx,
   output logic              done
);

   localparam int I_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int ACC_W = $clog2(N_IN + 1);
   localparam logic [I_W-1:0] I_LAST = I_W'(N_IN - 1);
   localparam logic [N_W-1:0] N_LAST = N_W'(N_OUT - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, EMIT} state_t;

   state_t            state;
   logic [N_W-1:0]    n;
   logic [I_W-1:0]    i;
   logic [I_W-1:0]    i_d;      // input index of the read now returning on w_data
   logic              rd_vld;   // w_data carries a requested weight this cycle
   logic [ACC_W-1:0]  acc;
   logic [N_IN-1:0]   act_q;

   assign w_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(n) * ADDR_W'(N_IN) + ADDR_W'(i);
   assign out_idx = n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         n         <= '0;
         i         <= '0;
         i_d       <= '0;
         rd_vld    <= 1'b0;
         acc       <= '0;
         act_q     <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_bit   <= 1'b0;
         done      <= 1'b0;
      end else begin
         done   <= 1'b0;
         rd_vld <= 1'b0;
         // Matching weight/activation bits add one; the count is independent of state.
         if (rd_vld)
            acc <= acc + ACC_W'(w_data ~^ act_q[i_d]);

         case (state)
            IDLE: begin
               if (start) begin
                  act_q <= act_in;
                  n     <= '0;
                  i     <= '0;
                  acc   <= '0;
                  busy  <= 1'b1;
                  state <= FETCH;
               end
            end
            FETCH: begin
               rd_vld <= 1'b1;
               i_d    <= i;
               if (i == I_LAST) begin
                  i     <= '0;
                  state <= DRAIN;
               end else begin
                  i <= i + 1'b1;
               end
            end
            DRAIN: state <= EMIT;   // absorbs the final read
            EMIT: begin
               // First EMIT cycle registers the thresholded count; the result
               // then stays put until the consumer takes it.
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_bit   <= (32'(acc) >= THRESH);
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  out_bit   <= 1'b0;
                  if (n == N_LAST) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     n     <= n + 1'b1;
                     acc   <= '0;
                     state <= FETCH;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
